h_eqlz_seq: RTL and testbench
=============================

// Module: h_eqlz_seq
// PURPOSE
//  Builds the per-symbol channel-estimate vector for the equaliser. Takes NUM_PILOT pilot estimates
//  (direct) and NUM_DIV interpolation results (divider outputs), and streams NUM_SC coefficients.
//  Coefficients go out in ascending subcarrier order, with a valid/ready handshake.
//  Pilot positions are pilot_off + m*PILOT_SPACING. Sits between the interpolation divider and the equaliser.
// PARAMETERS
//  WIDTH         16  bits per coefficient (packed I/Q as produced by the divider)
//  NUM_SC        12  subcarriers per symbol. Must be a multiple of PILOT_SPACING.
//  PILOT_SPACING 6   subcarrier distance between pilots
//  (derived) NUM_PILOT = NUM_SC/PILOT_SPACING; NUM_DIV = NUM_SC-NUM_PILOT
//  (derived) OFF_W = $clog2(PILOT_SPACING); IDX_W = $clog2(NUM_SC)
// PORTS
//  clk           in   1                  clock, all logic on rising edge
//  rst           in   1                  synchronous, active-high reset
//  flush         in   1                  synchronous abort of current symbol
//  in_valid      in   1                  symbol data on input buses valid
//  in_ready      out  1                  block accepts a symbol this cycle
//  pilot_off     in   OFF_W              offset of first pilot within the PILOT_SPACING group
//  est_bus       in   NUM_PILOT*WIDTH    pilot estimates; slot m (LSB first) is pilot m
//  div_bus       in   NUM_DIV*WIDTH      interpolated values; slot j is j-th non-pilot subcarrier, ascending
//  out_valid     out  1                  h_eqlz valid
//  out_ready     in   1                  equaliser accepts h_eqlz
//  h_eqlz        out  WIDTH              coefficient for subcarrier sc_idx
//  sc_idx        out  IDX_W              subcarrier index of current beat
//  out_is_pilot  out  1                  current beat sourced from est_bus
//  out_last      out  1                  sc_idx == NUM_SC-1
//  err_off       out  1                  one-cycle pulse: load attempted with pilot_off >= PILOT_SPACING
// BEHAVIOUR
//  - Reset:
//    - rst: state=IDLE; counters=0; out_valid=0; err_off=0.
//    - Buffers need not be cleared.
//  - Output zeroing: h_eqlz, sc_idx, out_is_pilot and out_last are 0 whenever out_valid=0.
//  - FSM states: IDLE, STREAM.
//  - IDLE:
//    - in_ready=1.
//    - in_valid with legal pilot_off: register est_bus, div_bus and pilot_off; clear sc_idx, p_cnt and d_cnt; go to STREAM.
//    - in_valid with illegal pilot_off: nothing captured; err_off=1 next cycle; stay IDLE.
//  - STREAM:
//    - out_valid=1.
//    - is_pilot = ((sc_idx mod PILOT_SPACING) == pilot_off_q).
//    - h_eqlz = is_pilot ? est[p_cnt] : div[d_cnt]. Combinational from registers; no extra latency.
//    - On each out_valid && out_ready: sc_idx++; p_cnt++ if is_pilot, else d_cnt++.
//    - Without out_ready: all outputs held stable.
//  - Latency: first beat is valid the cycle after acceptance. NUM_SC beats per symbol at full throughput.
//  - Back-to-back symbols:
//    - in_ready is also 1 during a handshaked out_last beat. This is a combinational path out_ready->in_ready.
//    - If in_valid is present then: load the new symbol and stay in STREAM with counters cleared. No bubble.
//    - Otherwise: return to IDLE.
//  - Priority: rst > flush > handshakes.
//  - flush: go to IDLE; out_valid=0 next cycle; any simultaneous in_valid is ignored.
//  - Wrap-around: sc_idx never exceeds NUM_SC-1.
//    - Internal assertion: at out_last, p_cnt==NUM_PILOT-1 or d_cnt==NUM_DIV-1, whichever fed that beat.
//  - No data dependence on the WIDTH content; values pass unmodified.
// STRUCTURE
//  - Shared package h_eqlz_pkg holds:
//    - the state encoding (IDLE=1'b0, STREAM=1'b1);
//    - the default NB-IoT constants (NUM_SC=12, PILOT_SPACING=6);
//    - the pilot-offset legality function.
//  - One sub-module: h_eqlz_src_sel, combinational. Inputs: sc_idx, pilot_off_q, p_cnt, d_cnt, buffers.
//    Outputs: is_pilot and h_eqlz.
//  - The FSM, counters and buffers stay in h_eqlz_seq.
// TESTING
//  1) pilot_off=2, est={BBBB,AAAA}, div=0x0001..0x000A, out_ready=1
//     -> h_eqlz 1,2,AAAA,3,4,5,6,7,BBBB,8,9,A.
//     Pilot flag at sc 2 and 8; out_last at sc 11.
//  2) pilot_off=6
//     -> err_off pulses 1 cycle; out_valid stays 0; next legal load is accepted normally.
//  3) Same as 1, with out_ready toggled 1,0,0,1...
//     -> same 12-value sequence; outputs stable while out_ready=0.
//  4) Two symbols back-to-back: pilot_off=0, then pilot_off=5, in_valid held.
//     -> 24 consecutive beats, no gap.
//     Pilots at sc 0,6 then sc 5,11; in_ready high only in IDLE/last beat.
//  5) flush at sc_idx=4
//     -> out_valid=0 next cycle; state IDLE.
//     rst at sc_idx=7 -> same, with all outputs 0.
//  6) pilot_off=5
//     -> last beat (sc 11) is est[1], first beat is div[0].

Source files
------------

// File: rtl/h_eqlz_pkg.sv
// Shared definitions for the channel-estimate sequencer: state encoding,
// NB-IoT default dimensions and the pilot-offset legality check.
package h_eqlz_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    localparam int DEF_NUM_SC        = 12;
    localparam int DEF_PILOT_SPACING = 6;

    function automatic logic off_legal(input int off, input int spacing);
        return (off >= 0) && (off < spacing);
    endfunction

endpackage

// File: rtl/h_eqlz_src_sel.sv
// Picks the coefficient for the current subcarrier: the next pilot estimate when the
// subcarrier sits on the pilot grid, otherwise the next interpolated value.
module h_eqlz_src_sel
    import h_eqlz_pkg::*;
#(
    parameter  int WIDTH         = 16,
    parameter  int NUM_SC        = DEF_NUM_SC,
    parameter  int PILOT_SPACING = DEF_PILOT_SPACING,
    localparam int NUM_PILOT     = NUM_SC / PILOT_SPACING,
    localparam int NUM_DIV       = NUM_SC - NUM_PILOT,
    localparam int OFF_W         = (PILOT_SPACING > 1) ? $clog2(PILOT_SPACING) : 1,
    localparam int IDX_W         = $clog2(NUM_SC),
    localparam int PC_W          = (NUM_PILOT > 1) ? $clog2(NUM_PILOT) : 1,
    localparam int DC_W          = (NUM_DIV > 1) ? $clog2(NUM_DIV) : 1
) (
    input  logic [IDX_W-1:0]           sc_idx,
    input  logic [OFF_W-1:0]           pilot_off_q,
    input  logic [PC_W-1:0]            p_cnt,
    input  logic [DC_W-1:0]            d_cnt,
    input  logic [NUM_PILOT*WIDTH-1:0] est_q,
    input  logic [NUM_DIV*WIDTH-1:0]   div_q,
    output logic                       is_pilot,
    output logic [WIDTH-1:0]           h_eqlz
);

    logic [IDX_W-1:0] sc_mod;

    assign sc_mod   = sc_idx % IDX_W'(PILOT_SPACING);
    assign is_pilot = (sc_mod == IDX_W'(pilot_off_q));
    assign h_eqlz   = is_pilot ? est_q[int'(p_cnt)*WIDTH +: WIDTH]
                               : div_q[int'(d_cnt)*WIDTH +: WIDTH];

endmodule

// File: rtl/h_eqlz_seq.sv
// Per-symbol channel-estimate sequencer: captures pilot estimates and interpolated
// values, then streams NUM_SC coefficients in ascending subcarrier order.
module h_eqlz_seq
    import h_eqlz_pkg::*;
#(
    parameter  int WIDTH         = 16,
    parameter  int NUM_SC        = DEF_NUM_SC,
    parameter  int PILOT_SPACING = DEF_PILOT_SPACING,
    localparam int NUM_PILOT     = NUM_SC / PILOT_SPACING,
    localparam int NUM_DIV       = NUM_SC - NUM_PILOT,
    localparam int OFF_W         = (PILOT_SPACING > 1) ? $clog2(PILOT_SPACING) : 1,
    localparam int IDX_W         = $clog2(NUM_SC),
    localparam int PC_W          = (NUM_PILOT > 1) ? $clog2(NUM_PILOT) : 1,
    localparam int DC_W          = (NUM_DIV > 1) ? $clog2(NUM_DIV) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OFF_W-1:0]           pilot_off,
    input  logic [NUM_PILOT*WIDTH-1:0] est_bus,
    input  logic [NUM_DIV*WIDTH-1:0]   div_bus,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           h_eqlz,
    output logic [IDX_W-1:0]           sc_idx,
    output logic                       out_is_pilot,
    output logic                       out_last,
    output logic                       err_off
);

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           sc_idx_q, sc_idx_d;
    logic [PC_W-1:0]            p_cnt_q, p_cnt_d;
    logic [DC_W-1:0]            d_cnt_q, d_cnt_d;
    logic                       err_q, err_d;
    logic [NUM_PILOT*WIDTH-1:0] est_q;
    logic [NUM_DIV*WIDTH-1:0]   div_q;
    logic [OFF_W-1:0]           off_q;

    logic                       load;
    logic                       off_ok;
    logic                       streaming;
    logic                       out_hs;
    logic                       beat_last;
    logic                       is_pilot;
    logic [WIDTH-1:0]           sel_data;

    h_eqlz_src_sel #(
        .WIDTH         (WIDTH),
        .NUM_SC        (NUM_SC),
        .PILOT_SPACING (PILOT_SPACING)
    ) u_src_sel (
        .sc_idx      (sc_idx_q),
        .pilot_off_q (off_q),
        .p_cnt       (p_cnt_q),
        .d_cnt       (d_cnt_q),
        .est_q       (est_q),
        .div_q       (div_q),
        .is_pilot    (is_pilot),
        .h_eqlz      (sel_data)
    );

    assign off_ok    = off_legal(int'(pilot_off), PILOT_SPACING);
    assign streaming = (state_q == STREAM);
    assign out_hs    = streaming && out_ready;
    assign beat_last = streaming && (sc_idx_q == IDX_W'(NUM_SC - 1));
    // A handshaked last beat frees the buffers, so a new symbol can land with no bubble.
    assign in_ready  = (state_q == IDLE) || (out_hs && beat_last);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        sc_idx_d = sc_idx_q;
        p_cnt_d  = p_cnt_q;
        d_cnt_d  = d_cnt_q;
        err_d    = 1'b0;
        load     = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            if (in_valid && in_ready) begin
                if (off_ok) load  = 1'b1;
                else        err_d = 1'b1;
            end
            if (out_hs) begin
                if (beat_last) begin
                    state_d = IDLE;
                end else begin
                    sc_idx_d = sc_idx_q + IDX_W'(1);
                    if (is_pilot) p_cnt_d = p_cnt_q + PC_W'(1);
                    else          d_cnt_d = d_cnt_q + DC_W'(1);
                end
            end
            if (load) begin
                state_d  = STREAM;
                sc_idx_d = '0;
                p_cnt_d  = '0;
                d_cnt_d  = '0;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sc_idx_q <= '0;
            p_cnt_q  <= '0;
            d_cnt_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sc_idx_q <= sc_idx_d;
            p_cnt_q  <= p_cnt_d;
            d_cnt_q  <= d_cnt_d;
            err_q    <= err_d;
        end
    end

    // NOTE: symbol buffers carry no reset; they are only read while STREAM, after a load.
    always_ff @(posedge clk) begin
        if (load) begin
            est_q <= est_bus;
            div_q <= div_bus;
            off_q <= pilot_off;
        end
    end

    assign out_valid    = streaming;
    assign h_eqlz       = streaming ? sel_data : '0;
    assign sc_idx       = streaming ? sc_idx_q : '0;
    assign out_is_pilot = streaming && is_pilot;
    assign out_last     = beat_last;
    assign err_off      = err_q;

    // The final beat must consume the last entry of whichever buffer feeds it.
    a_last_cnt : assert property (@(posedge clk) disable iff (rst)
        beat_last |-> (is_pilot ? (p_cnt_q == PC_W'(NUM_PILOT - 1))
                                : (d_cnt_q == DC_W'(NUM_DIV - 1))));

endmodule

// File: tb/tb_h_eqlz_seq.sv
// Self-checking bench for h_eqlz_seq: directed scenarios plus randomized symbols,
// compared against a queue-based model of the subcarrier ordering rules.
module tb_h_eqlz_seq;

    localparam int WIDTH = 16;
    localparam int NUM_SC = 12;
    localparam int PS = 6;
    localparam int NP = NUM_SC / PS;
    localparam int ND = NUM_SC - NP;
    localparam int OFF_W = $clog2(PS);
    localparam int IDX_W = $clog2(NUM_SC);

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic out_is_pilot, out_last, err_off;
    logic [OFF_W-1:0] pilot_off;
    logic [NP*WIDTH-1:0] est_bus;
    logic [ND*WIDTH-1:0] div_bus;
    logic [WIDTH-1:0] h_eqlz;
    logic [IDX_W-1:0] sc_idx;

    int total = 0;
    int bad = 0;

    logic [WIDTH-1:0] exp_h [2][NUM_SC];
    logic             exp_p [2][NUM_SC];

    always #5 clk = ~clk;

    h_eqlz_seq dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pilot_off    (pilot_off),
        .est_bus      (est_bus),
        .div_bus      (div_bus),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .h_eqlz       (h_eqlz),
        .sc_idx       (sc_idx),
        .out_is_pilot (out_is_pilot),
        .out_last     (out_last),
        .err_off      (err_off)
    );

    // Advance to the next falling edge, passing one rising edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: walk subcarriers in order; grid positions pop the next pilot, others the next divider value.
    task automatic build_model(input int slot, input int off,
                               input logic [NP*WIDTH-1:0] e, input logic [ND*WIDTH-1:0] d);
        logic [WIDTH-1:0] pq [$];
        logic [WIDTH-1:0] dq [$];
        for (int m = 0; m < NP; m++) pq.push_back(e[m*WIDTH +: WIDTH]);
        for (int j = 0; j < ND; j++) dq.push_back(d[j*WIDTH +: WIDTH]);
        for (int s = 0; s < NUM_SC; s++) begin
            exp_p[slot][s] = ((s % PS) == off);
            exp_h[slot][s] = exp_p[slot][s] ? pq.pop_front() : dq.pop_front();
        end
    endtask

    task automatic rand_buses(output logic [NP*WIDTH-1:0] e, output logic [ND*WIDTH-1:0] d);
        for (int m = 0; m < NP; m++) e[m*WIDTH +: WIDTH] = WIDTH'($urandom);
        for (int j = 0; j < ND; j++) d[j*WIDTH +: WIDTH] = WIDTH'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pilot_off = '0; est_bus = '0; div_bus = '0;
        step(); step();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
        total++; if (err_off !== 1'b0) begin bad++; $display("FAIL reset_err: got %b exp 0", err_off); end
        total++; if (h_eqlz !== '0) begin bad++; $display("FAIL reset_h: got %h exp 0", h_eqlz); end
        total++; if (sc_idx !== '0) begin bad++; $display("FAIL reset_idx: got %0d exp 0", sc_idx); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        rst = 1'b0;
        step();
    endtask

    // Scenario 1 against the literal sequence rather than the model.
    task automatic test_basic();
        logic [WIDTH-1:0] tab [NUM_SC];
        tab = '{16'h0001, 16'h0002, 16'hAAAA, 16'h0003, 16'h0004, 16'h0005,
                16'h0006, 16'h0007, 16'hBBBB, 16'h0008, 16'h0009, 16'h000A};
        pilot_off = OFF_W'(2);
        est_bus = {16'hBBBB, 16'hAAAA};
        for (int j = 0; j < ND; j++) div_bus[j*WIDTH +: WIDTH] = WIDTH'(j + 1);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_accept: got %b exp 1", in_ready); end
        step();
        in_valid = 1'b0;
        for (int s = 0; s < NUM_SC; s++) begin
            #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid sc%0d: got %b exp 1", s, out_valid); end
            total++; if (h_eqlz !== tab[s]) begin bad++; $display("FAIL basic_h sc%0d: got %h exp %h", s, h_eqlz, tab[s]); end
            total++; if (sc_idx !== IDX_W'(s)) begin bad++; $display("FAIL basic_idx: got %0d exp %0d", sc_idx, s); end
            total++; if (out_is_pilot !== (s == 2 || s == 8)) begin bad++; $display("FAIL basic_pilot sc%0d: got %b", s, out_is_pilot); end
            total++; if (out_last !== (s == 11)) begin bad++; $display("FAIL basic_last sc%0d: got %b", s, out_last); end
            step();
        end
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_end_valid: got %b exp 0", out_valid); end
    endtask

    // One symbol through the model; stall_mode 0 = always ready, 1 = ready 1,0,0 repeating, 2 = random.
    task automatic test_symbol(input string name, input int off, input logic [NP*WIDTH-1:0] e,
                               input logic [ND*WIDTH-1:0] d, input int stall_mode);
        int beat;
        int cyc;
        build_model(0, off, e, d);
        pilot_off = OFF_W'(off); est_bus = e; div_bus = d;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_accept: got %b exp 1", name, in_ready); end
        step();
        in_valid = 1'b0; est_bus = ~e; div_bus = ~d;
        beat = 0; cyc = 0;
        while (beat < NUM_SC && cyc < 200) begin
            case (stall_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 3) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_valid b%0d: got %b exp 1", name, beat, out_valid); end
            total++; if (h_eqlz !== exp_h[0][beat]) begin bad++; $display("FAIL %s_h b%0d: got %h exp %h", name, beat, h_eqlz, exp_h[0][beat]); end
            total++; if (sc_idx !== IDX_W'(beat)) begin bad++; $display("FAIL %s_idx: got %0d exp %0d", name, sc_idx, beat); end
            total++; if (out_is_pilot !== exp_p[0][beat]) begin bad++; $display("FAIL %s_pilot b%0d: got %b exp %b", name, beat, out_is_pilot, exp_p[0][beat]); end
            total++; if (out_last !== (beat == NUM_SC - 1)) begin bad++; $display("FAIL %s_last b%0d: got %b", name, beat, out_last); end
            total++; if (in_ready !== (beat == NUM_SC - 1 && out_ready)) begin bad++; $display("FAIL %s_in_ready b%0d: got %b", name, beat, in_ready); end
            if (out_ready) beat++;
            cyc++;
            step();
        end
        total++; if (cyc >= 200) begin bad++; $display("FAIL %s_timeout: got %0d beats exp %0d", name, beat, NUM_SC); end
        out_ready = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_end_valid: got %b exp 0", name, out_valid); end
    endtask

    task automatic test_bad_off();
        logic [NP*WIDTH-1:0] e;
        logic [ND*WIDTH-1:0] d;
        for (int bad_off = PS; bad_off < (1 << OFF_W); bad_off++) begin
            pilot_off = OFF_W'(bad_off); in_valid = 1'b1;
            #1;
            total++; if (err_off !== 1'b0) begin bad++; $display("FAIL badoff_pre_err: got %b exp 0", err_off); end
            step();
            in_valid = 1'b0;
            #1;
            total++; if (err_off !== 1'b1) begin bad++; $display("FAIL badoff_err off%0d: got %b exp 1", bad_off, err_off); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL badoff_valid: got %b exp 0", out_valid); end
            step();
            #1;
            total++; if (err_off !== 1'b0) begin bad++; $display("FAIL badoff_pulse: got %b exp 0", err_off); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL badoff_valid2: got %b exp 0", out_valid); end
            step();
        end
        rand_buses(e, d);
        test_symbol("after_badoff", 3, e, d, 0);
    endtask

    task automatic test_back_to_back();
        logic [NP*WIDTH-1:0] ea, eb;
        logic [ND*WIDTH-1:0] da, db;
        int a;
        rand_buses(ea, da);
        rand_buses(eb, db);
        build_model(0, 0, ea, da);
        build_model(1, 5, eb, db);
        pilot_off = OFF_W'(0); est_bus = ea; div_bus = da; in_valid = 1'b1; out_ready = 1'b1;
        step();
        pilot_off = OFF_W'(5); est_bus = eb; div_bus = db;
        for (int b = 0; b < 2 * NUM_SC; b++) begin
            a = b % NUM_SC;
            if (b == 2 * NUM_SC - 1) in_valid = 1'b0;
            #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid b%0d: got %b exp 1", b, out_valid); end
            total++; if (sc_idx !== IDX_W'(a)) begin bad++; $display("FAIL b2b_idx b%0d: got %0d exp %0d", b, sc_idx, a); end
            total++; if (h_eqlz !== exp_h[b / NUM_SC][a]) begin bad++; $display("FAIL b2b_h b%0d: got %h exp %h", b, h_eqlz, exp_h[b / NUM_SC][a]); end
            total++; if (out_is_pilot !== exp_p[b / NUM_SC][a]) begin bad++; $display("FAIL b2b_pilot b%0d: got %b exp %b", b, out_is_pilot, exp_p[b / NUM_SC][a]); end
            total++; if (in_ready !== (a == NUM_SC - 1)) begin bad++; $display("FAIL b2b_in_ready b%0d: got %b", b, in_ready); end
            step();
        end
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_valid: got %b exp 0", out_valid); end
    endtask

    task automatic test_flush_rst();
        logic [NP*WIDTH-1:0] e;
        logic [ND*WIDTH-1:0] d;
        rand_buses(e, d);
        pilot_off = OFF_W'(1); est_bus = e; div_bus = d; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        #1;
        total++; if (sc_idx !== IDX_W'(4)) begin bad++; $display("FAIL flush_pre_idx: got %0d exp 4", sc_idx); end
        flush = 1'b1; in_valid = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b exp 0", out_valid); end
        total++; if (h_eqlz !== '0) begin bad++; $display("FAIL flush_h: got %h exp 0", h_eqlz); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_idle: got %b exp 1", in_ready); end
        step();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ignored_load: got %b exp 0", out_valid); end

        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        #1;
        total++; if (sc_idx !== IDX_W'(7)) begin bad++; $display("FAIL rst_pre_idx: got %0d exp 7", sc_idx); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b exp 0", out_valid); end
        total++; if ({h_eqlz, sc_idx, out_is_pilot, out_last, err_off} !== '0) begin
            bad++; $display("FAIL rst_outputs: got h=%h idx=%0d p=%b l=%b e=%b exp all 0", h_eqlz, sc_idx, out_is_pilot, out_last, err_off);
        end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b exp 1", in_ready); end
        step();
    endtask

    task automatic test_random();
        logic [NP*WIDTH-1:0] e;
        logic [ND*WIDTH-1:0] d;
        for (int k = 0; k < 8; k++) begin
            rand_buses(e, d);
            test_symbol("rand", int'($urandom_range(0, PS - 1)), e, d, 2);
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    initial begin
        logic [NP*WIDTH-1:0] e;
        logic [ND*WIDTH-1:0] d;
        test_reset();
        test_basic();
        test_bad_off();
        for (int j = 0; j < ND; j++) d[j*WIDTH +: WIDTH] = WIDTH'(j + 1);
        test_symbol("backpressure", 2, {16'hBBBB, 16'hAAAA}, d, 1);
        test_back_to_back();
        test_flush_rst();
        rand_buses(e, d);
        test_symbol("off5", 5, e, d, 0);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
